// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver.
//   PAR_*        parity-mode codes for the PARITY parameter
//   rx_state_e   receiver FSM encoding
//   calc_div     system clocks per oversample tick (truncated)
//   clog2_min1   counter width helper, never returns 0
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_e;

  function automatic int calc_div(input int clk_hz, input int baud, input int osr);
    return clk_hz / (baud * osr);
  endfunction

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: clock divider plus per-bit phase counter.
//   clk_i      system clock
//   rst_i      synchronous reset, active-high
//   restart_i  zero both counters (start edge seen) so sampling aligns to it
//   tick_o     one-cycle pulse every DIV clocks
//   phase_o    oversample phase within the current bit, 0..OSR-1
module uart_os_tick
  import uart_pkg::*;
#(
  parameter int DIV = 54,
  parameter int OSR = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          restart_i,
  output logic                          tick_o,
  output logic [clog2_min1(OSR)-1:0]    phase_o
);

  localparam int CW = clog2_min1(DIV);
  localparam int PW = clog2_min1(OSR);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [PW-1:0] PH_MAX  = PW'(OSR - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] ph_q, ph_d;

  always_comb begin
    tick_o = (cnt_q == CNT_MAX);
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
    ph_d   = ph_q;
    if (tick_o) ph_d = (ph_q == PH_MAX) ? '0 : ph_q + 1'b1;
    if (restart_i) begin
      cnt_d = '0;
      ph_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ph_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  assign phase_o = ph_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/odd/even parity, 1-2 stop
// bits, 3-sample majority vote per bit, one-entry valid/ready output buffer.
//   clk        system clock
//   rst        synchronous reset, active-high
//   rxd        async serial input, idle high
//   rdy_rx     consumer ready
//   d_rx       received word, LSB first on the line
//   vld_rx     d_rx and flags hold an unconsumed word
//   par_err    parity mismatch for the word in d_rx
//   frame_err  a stop bit was voted 0 for the word in d_rx
//   overrun    one-cycle pulse: finished frame dropped because buffer was full
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int OSR       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 rdy_rx,
  output logic [DATA_BITS-1:0] d_rx,
  output logic                 vld_rx,
  output logic                 par_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OSR);
  localparam int PW  = clog2_min1(OSR);
  // Samples are taken on the ticks that enter phases OSR/2-1, OSR/2 and
  // OSR/2+1, i.e. while the counter still shows the preceding phase.
  localparam logic [PW-1:0] PH_S0 = PW'(OSR/2 - 2);
  localparam logic [PW-1:0] PH_S1 = PW'(OSR/2 - 1);
  localparam logic [PW-1:0] PH_V  = PW'(OSR/2);
  localparam logic [3:0] LAST_DBIT = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_SBIT = 4'(STOP_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_prev_q;
  logic                 rx_s;
  logic                 tick, restart, vote_en, vote, done;
  logic [PW-1:0]        phase;
  rx_state_e            state_q, state_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic                 pacc_q, pacc_d, facc_q, facc_d;
  logic [DATA_BITS-1:0] d_q;
  logic                 vld_q, perr_q, ferr_q, ovr_q;

  assign rx_s = sync_q[1];

  uart_os_tick #(.DIV(DIV), .OSR(OSR)) u_tick (
    .clk_i     (clk),
    .rst_i     (rst),
    .restart_i (restart),
    .tick_o    (tick),
    .phase_o   (phase)
  );

  assign vote_en = tick & (phase == PH_V);
  assign vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    pacc_d  = pacc_q;
    facc_d  = facc_q;
    restart = 1'b0;
    done    = 1'b0;
    if (tick && phase == PH_S0) smp_d[0] = rx_s;
    if (tick && phase == PH_S1) smp_d[1] = rx_s;
    unique case (state_q)
      ST_IDLE: if (rx_prev_q && !rx_s) begin
        restart = 1'b1;
        state_d = ST_START;
        bcnt_d  = '0;
        pacc_d  = 1'b0;
        facc_d  = 1'b0;
      end
      ST_START: if (vote_en) state_d = vote ? ST_IDLE : ST_DATA;
      ST_DATA: if (vote_en) begin
        shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
        bcnt_d  = bcnt_q + 4'd1;
        if (bcnt_q == LAST_DBIT) begin
          bcnt_d  = '0;
          state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: if (vote_en) begin
        pacc_d  = ((^shreg_q) ^ vote) != (PARITY == PAR_ODD);
        state_d = ST_STOP;
      end
      ST_STOP: if (vote_en) begin
        facc_d = facc_q | ~vote;
        bcnt_d = bcnt_q + 4'd1;
        // Leave at mid-bit so a start edge half a bit later is still caught.
        if (bcnt_q == LAST_SBIT) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      smp_q     <= '0;
      shreg_q   <= '0;
      bcnt_q    <= '0;
      pacc_q    <= 1'b0;
      facc_q    <= 1'b0;
      d_q       <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      smp_q     <= smp_d;
      shreg_q   <= shreg_d;
      bcnt_q    <= bcnt_d;
      pacc_q    <= pacc_d;
      facc_q    <= facc_d;
      ovr_q     <= done & vld_q & ~rdy_rx;
      // A word consumed in the same cycle frees the slot for the new frame.
      if (done && (!vld_q || rdy_rx)) begin
        d_q    <= shreg_q;
        perr_q <= pacc_d;
        ferr_q <= facc_d;
        vld_q  <= 1'b1;
      end else if (vld_q && rdy_rx) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign d_rx      = d_q;
  assign vld_rx    = vld_q;
  assign par_err   = perr_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench: three receivers (8N1, 8E1, 7O2) at 115200 baud / OSR 16
// from a 100 MHz clock, each driven by its own stimulus thread in parallel.
module tb_uart_rx_cfg;

  localparam int BIT = 864;

  logic       clk = 1'b0;
  logic [2:0] rst_v = 3'b111;
  logic [2:0] rxd_v = 3'b111;
  logic [2:0] rdy_v = 3'b111;
  logic [2:0] vld_a, pe_a, fe_a, ov_a, vld_prev;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] d_a [3];
  logic [8:0] last_d [3];
  logic       last_pe [3], last_fe [3];
  int         dcnt [3], ocnt [3];
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLK_HZ(100_000_000), .BAUD(115200), .OSR(16), .DATA_BITS(8),
                .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .rxd(rxd_v[0]), .rdy_rx(rdy_v[0]), .d_rx(d0),
    .vld_rx(vld_a[0]), .par_err(pe_a[0]), .frame_err(fe_a[0]), .overrun(ov_a[0]));

  uart_rx_cfg #(.CLK_HZ(100_000_000), .BAUD(115200), .OSR(16), .DATA_BITS(8),
                .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst_v[1]), .rxd(rxd_v[1]), .rdy_rx(rdy_v[1]), .d_rx(d1),
    .vld_rx(vld_a[1]), .par_err(pe_a[1]), .frame_err(fe_a[1]), .overrun(ov_a[1]));

  uart_rx_cfg #(.CLK_HZ(100_000_000), .BAUD(115200), .OSR(16), .DATA_BITS(7),
                .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .rxd(rxd_v[2]), .rdy_rx(rdy_v[2]), .d_rx(d2),
    .vld_rx(vld_a[2]), .par_err(pe_a[2]), .frame_err(fe_a[2]), .overrun(ov_a[2]));

  assign d_a[0] = {1'b0, d0};
  assign d_a[1] = {1'b0, d1};
  assign d_a[2] = {2'b00, d2};

  // Delivery monitor: a rising vld_rx marks a newly loaded word.
  initial begin
    vld_prev = '0;
    for (int c = 0; c < 3; c++) begin
      dcnt[c] = 0; ocnt[c] = 0; last_d[c] = '0; last_pe[c] = 1'b0; last_fe[c] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      if (vld_a[c] && !vld_prev[c]) begin
        dcnt[c]    <= dcnt[c] + 1;
        last_d[c]  <= d_a[c];
        last_pe[c] <= pe_a[c];
        last_fe[c] <= fe_a[c];
      end
      if (ov_a[c]) ocnt[c] <= ocnt[c] + 1;
      vld_prev[c] <= vld_a[c];
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Bits go out LSB first, one bit-time each; line returns to idle afterwards.
  task automatic send(input int ch, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd_v[ch] = bits[i];
      repeat (BIT) @(negedge clk);
    end
    rxd_v[ch] = 1'b1;
  endtask

  task automatic idle(input int ch, input int cycles);
    rxd_v[ch] = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic run_8n1();
    idle(0, 2 * BIT);
    send(0, 16'({1'b1, 8'hA5, 1'b0}), 10);
    idle(0, 20);
    chk("8n1_a5_cnt", dcnt[0], 1);
    chk("8n1_a5_d",   last_d[0], 'hA5);
    chk("8n1_a5_pe",  last_pe[0], 0);
    chk("8n1_a5_fe",  last_fe[0], 0);
    // 300-clock glitch: the mid-bit vote sees high, so no frame.
    rxd_v[0] = 1'b0;
    repeat (300) @(negedge clk);
    idle(0, 2 * BIT);
    chk("glitch_cnt", dcnt[0], 1);
    send(0, 16'({1'b1, 8'h55, 1'b0}), 10);
    idle(0, 20);
    chk("after_glitch_cnt", dcnt[0], 2);
    chk("after_glitch_d",   last_d[0], 'h55);
    // Back-to-back frames with the consumer stalled.
    rdy_v[0] = 1'b0;
    send(0, 16'({1'b1, 8'h11, 1'b0}), 10);
    send(0, 16'({1'b1, 8'h22, 1'b0}), 10);
    idle(0, 20);
    chk("ovr_pulses", ocnt[0], 1);
    chk("ovr_cnt",    dcnt[0], 3);
    chk("ovr_vld",    vld_a[0], 1);
    chk("ovr_d_held", d_a[0], 'h11);
    rdy_v[0] = 1'b1;
    @(negedge clk);
    chk("consume_vld", vld_a[0], 0);
    idle(0, BIT);
    // Reset while DATA bit 5 of 0xF0 is on the line (line high from here on).
    send(0, 16'b100000, 6);
    repeat (400) @(negedge clk);
    rst_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst_v[0] = 1'b0;
    chk("midrst_vld", vld_a[0], 0);
    chk("midrst_d",   d_a[0], 0);
    idle(0, 4 * BIT);
    chk("midrst_cnt", dcnt[0], 3);
    send(0, 16'({1'b1, 8'h0F, 1'b0}), 10);
    idle(0, 20);
    chk("post_rst_cnt", dcnt[0], 4);
    chk("post_rst_d",   last_d[0], 'h0F);
    chk("post_rst_fe",  last_fe[0], 0);
  endtask

  task automatic run_8e1();
    idle(1, 2 * BIT);
    // 0x3C has four ones: even parity bit should be 0.
    send(1, 16'({1'b1, 1'b1, 8'h3C, 1'b0}), 11);
    idle(1, 20);
    chk("8e1_bad_cnt", dcnt[1], 1);
    chk("8e1_bad_d",   last_d[1], 'h3C);
    chk("8e1_bad_pe",  last_pe[1], 1);
    send(1, 16'({1'b1, 1'b0, 8'h3C, 1'b0}), 11);
    idle(1, 20);
    chk("8e1_ok_cnt", dcnt[1], 2);
    chk("8e1_ok_pe",  last_pe[1], 0);
    chk("8e1_ok_fe",  last_fe[1], 0);
  endtask

  task automatic run_7o2();
    idle(2, 2 * BIT);
    // 0x35 has four ones: odd parity bit 1; second stop bit forced low.
    send(2, 16'({1'b0, 1'b1, 1'b1, 7'h35, 1'b0}), 11);
    idle(2, BIT);
    chk("7o2_cnt", dcnt[2], 1);
    chk("7o2_d",   last_d[2], 'h35);
    chk("7o2_pe",  last_pe[2], 0);
    chk("7o2_fe",  last_fe[2], 1);
    // Break: 10 bit-times low covers start, data, parity and first stop.
    rxd_v[2] = 1'b0;
    repeat (10 * BIT) @(negedge clk);
    idle(2, 2 * BIT);
    chk("break_cnt", dcnt[2], 2);
    chk("break_d",   last_d[2], 0);
    chk("break_fe",  last_fe[2], 1);
    chk("break_pe",  last_pe[2], 1);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_vld", vld_a[0], 0);
    chk("rst_d",   d_a[0], 0);
    chk("rst_pe",  pe_a[0], 0);
    chk("rst_fe",  fe_a[0], 0);
    chk("rst_ovr", ov_a[0], 0);
    rst_v = 3'b000;
    repeat (2) @(negedge clk);
    fork
      run_8n1();
      run_8e1();
      run_7o2();
    join
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
